nbody_seq: RTL and testbench
============================

NBODY_SEQ -- requirements
Module: nbody_seq

Interface
REQ-001 Parameters (name, default, meaning): BODIES, 512, maximum body count; BODY_AW, $clog2(BODIES), body index width; DATA_WIDTH, 64, bus data width; ADDR_WIDTH, 16, bus address width; ACCL_LAT, 121, cycles from pair operands to acceleration out; ADD_LAT, 20, adder latency; RAM_LAT, 1, memory read latency.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- chipselect, read, write  in  1  bus strobes.
- addr  in  ADDR_WIDTH  register select in addr[3:0].
- writedata  in  DATA_WIDTH  bus write data.
- readdata  out  DATA_WIDTH  registered read data.
- irq  out  1  level interrupt.
- pi_addr, pj_addr  out  BODY_AW  pair read addresses.
- pair_valid  out  1  pair operands valid.
- acc_first, acc_last  out  1  first/last contributing pair of body i, aligned with pair_valid.
- v_wr_en  out  1  velocity writeback strobe.
- v_wr_addr  out  BODY_AW  velocity writeback body.
- p_rd_addr  out  BODY_AW  position-update read address.
- p_wr_en  out  1  position writeback strobe.
- p_wr_addr  out  BODY_AW  position writeback body.
- busy  out  1  high outside IDLE and DONE.

Function
REQ-003 Registers: 0 CTRL (bit0 start, bit1 abort, both self-clearing write-only; bit2 irq_en, R/W); 1 STATUS (bit0 done, W1C; bit1 busy; bit2 cfg_err; read-only except bit0); 2 N_BODIES; 3 ITERS; 4 ITER_COUNT (read-only); any other index reads all-ones.
REQ-004 readdata shall update one cycle after a read with chipselect high, and shall hold otherwise.
REQ-005 States: IDLE, ACCEL, DRAIN_A, UPDATE, DRAIN_U, DONE.
REQ-006 IDLE -> ACCEL on start when 2 <= N_BODIES <= BODIES; otherwise set cfg_err and stay in IDLE. A start that succeeds clears cfg_err, done and ITER_COUNT.
REQ-007 In ACCEL, issue one (i,j) per cycle: i outer, j inner, each 0..N-1. pair_valid = 0 when i == j (bubble).
REQ-008 acc_first marks the first valid j for i; acc_last marks the last valid j for i.
REQ-009 pair_valid, acc_first and acc_last are delayed RAM_LAT cycles relative to their addresses.
REQ-010 v_wr_en pulses exactly ACCL_LAT+ADD_LAT cycles after the acc_last cycle of body i, with v_wr_addr = i.
REQ-011 After issuing (N-1,N-1), go to DRAIN_A. Leave DRAIN_A for UPDATE when no v_wr_en remains in flight.
REQ-012 In UPDATE, p_rd_addr steps 0..N-1, one per cycle. p_wr_en pulses RAM_LAT+ADD_LAT cycles after each read, with p_wr_addr equal to that read address. Go to DRAIN_U after N-1.
REQ-013 On DRAIN_U empty: increment ITER_COUNT. If ITER_COUNT+1 >= max(ITERS,1), go to DONE and set done; otherwise go to ACCEL.
REQ-014 DONE -> IDLE on the cycle after done is cleared (W1C) or on start. A start in DONE is handled as a start in IDLE.
REQ-015 irq = done & irq_en.
REQ-016 Abort in any busy state: go to IDLE next cycle and clear all delay-line valids so no further v_wr_en/p_wr_en occur. done stays 0.
REQ-017 Writes to N_BODIES or ITERS while busy are ignored. Fields are zero-extended on read.
REQ-018 Simultaneous start and abort: abort wins.

Reset
REQ-019 On rst: state IDLE; all registers, readdata, delay lines and counters 0; all outputs 0.

Structure
REQ-020 nbody_pkg shall hold the state enum, register index constants and CTRL/STATUS bit positions.
REQ-021 One sub-module, nbody_delay (parameterised depth and width, valid-clearing flush), shall implement every latency-matching delay line.

Verification
REQ-022 Directed scenarios:
- N=3, ITERS=1, start -> 6 valid pairs of 9 issued; 3 v_wr_en at addresses 0,1,2; 3 p_wr_en; done=1; ITER_COUNT=1.
- N=1, start -> cfg_err=1, busy stays 0, no strobes.
- N=4, ITERS=3, irq_en=1 -> exactly 3 ACCEL/UPDATE rounds; irq rises with done; W1C on done drops irq and returns to IDLE.
- Abort during DRAIN_A with a v_wr_en 5 cycles out -> no strobe ever appears; IDLE next cycle; done=0.
- Write N_BODIES=7 while busy -> readback unchanged; current run completes with the old N.
- rst asserted mid-UPDATE -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/nbody_pkg.sv
// Shared types and register map for the n-body pair sequencer.
package nbody_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_DRAIN_A,
    S_UPDATE,
    S_DRAIN_U,
    S_DONE
  } state_e;

  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_STATUS     = 4'd1;
  localparam logic [3:0] REG_N_BODIES   = 4'd2;
  localparam logic [3:0] REG_ITERS      = 4'd3;
  localparam logic [3:0] REG_ITER_COUNT = 4'd4;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

  localparam int unsigned STAT_DONE    = 0;
  localparam int unsigned STAT_BUSY    = 1;
  localparam int unsigned STAT_CFG_ERR = 2;

  // Storage width of the N_BODIES / ITERS / ITER_COUNT fields.
  localparam int unsigned CFG_W = 32;

endpackage

// File: rtl/nbody_seq_if.sv
// Register bus between host and the n-body sequencer.
interface nbody_seq_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16
) ();
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  irq;

  modport master (output chipselect, read, write, addr, writedata,
                  input  readdata, irq);
  modport slave  (input  chipselect, read, write, addr, writedata,
                  output readdata, irq);
endinterface

// File: rtl/nbody_delay.sv
// Fixed-depth valid/data delay line; flush empties every stage at once.
module nbody_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      vld_q[0]  <= vld_i & ~flush_i;
      data_q[0] <= flush_i ? '0 : data_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        vld_q[k]  <= vld_q[k-1] & ~flush_i;
        data_q[k] <= flush_i ? '0 : data_q[k-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];
  assign busy_o = |vld_q;

endmodule

// File: rtl/nbody_seq.sv
// N-body pair sequencer: issues (i,j) force pairs, then position updates, per iteration.
module nbody_seq
  import nbody_pkg::*;
#(
  parameter int unsigned BODIES     = 512,
  parameter int unsigned BODY_AW    = $clog2(BODIES),
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ACCL_LAT   = 121,
  parameter int unsigned ADD_LAT    = 20,
  parameter int unsigned RAM_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  nbody_seq_if.slave         bus,
  output logic [BODY_AW-1:0] pi_addr,
  output logic [BODY_AW-1:0] pj_addr,
  output logic               pair_valid,
  output logic               acc_first,
  output logic               acc_last,
  output logic               v_wr_en,
  output logic [BODY_AW-1:0] v_wr_addr,
  output logic [BODY_AW-1:0] p_rd_addr,
  output logic               p_wr_en,
  output logic [BODY_AW-1:0] p_wr_addr,
  output logic               busy
);

  state_e               state_q;
  logic [BODY_AW-1:0]   i_q, j_q, pcnt_q;
  logic [CFG_W-1:0]     n_bodies_q, iters_q, iter_cnt_q;
  logic                 irq_en_q, done_q, cfg_err_q;
  logic [DATA_WIDTH-1:0] readdata_q, rdata_c;

  logic [3:0]   reg_sel;
  logic         wr_c, rd_c, ctrl_wr_c, start_c, abort_c, busy_c, cfg_ok_c, last_iter_c;
  logic [BODY_AW-1:0] n_last, j_first, j_last;
  logic [CFG_W-1:0]   iters_eff;
  logic         issue_c, pvld_c, first_c, last_c, upd_c;
  logic [BODY_AW+1:0] pair_data;
  logic [BODY_AW-1:0] pair_i;
  logic         pair_busy, v_busy, p_busy;
  logic         unused_bits;

  assign reg_sel   = bus.addr[3:0];
  assign wr_c      = bus.chipselect & bus.write;
  assign rd_c      = bus.chipselect & bus.read;
  assign ctrl_wr_c = wr_c && (reg_sel == REG_CTRL);
  assign busy_c    = (state_q != S_IDLE) && (state_q != S_DONE);
  // Abort beats start when both are written together.
  assign start_c   = ctrl_wr_c & bus.writedata[CTRL_START] & ~bus.writedata[CTRL_ABORT];
  assign abort_c   = ctrl_wr_c & bus.writedata[CTRL_ABORT] & busy_c;
  assign cfg_ok_c  = (n_bodies_q >= CFG_W'(2)) && (n_bodies_q <= CFG_W'(BODIES));
  assign iters_eff = (iters_q == '0) ? CFG_W'(1) : iters_q;
  assign last_iter_c = (iter_cnt_q + CFG_W'(1)) >= iters_eff;
  assign unused_bits = ^{bus.addr[ADDR_WIDTH-1:4], bus.writedata[DATA_WIDTH-1:CFG_W]};

  // First/last valid partner j for body i, skipping the i==j bubble.
  assign n_last  = BODY_AW'(n_bodies_q - CFG_W'(1));
  assign j_first = (i_q == '0) ? BODY_AW'(1) : '0;
  assign j_last  = (i_q == n_last) ? n_last - BODY_AW'(1) : n_last;
  assign issue_c = (state_q == S_ACCEL);
  assign pvld_c  = issue_c && (i_q != j_q);
  assign first_c = pvld_c && (j_q == j_first);
  assign last_c  = pvld_c && (j_q == j_last);
  assign upd_c   = (state_q == S_UPDATE);

  always_comb begin
    rdata_c = '1;
    case (reg_sel)
      REG_CTRL:       rdata_c = DATA_WIDTH'({irq_en_q, 2'b00});
      REG_STATUS:     rdata_c = DATA_WIDTH'({cfg_err_q, busy_c, done_q});
      REG_N_BODIES:   rdata_c = DATA_WIDTH'(n_bodies_q);
      REG_ITERS:      rdata_c = DATA_WIDTH'(iters_q);
      REG_ITER_COUNT: rdata_c = DATA_WIDTH'(iter_cnt_q);
      default:        rdata_c = '1;
    endcase
  end

  // Register file and sequencing FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      pcnt_q     <= '0;
      n_bodies_q <= '0;
      iters_q    <= '0;
      iter_cnt_q <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (rd_c) readdata_q <= rdata_c;
      if (ctrl_wr_c) irq_en_q <= bus.writedata[CTRL_IRQ_EN];
      if (wr_c && reg_sel == REG_STATUS && bus.writedata[STAT_DONE]) done_q <= 1'b0;
      if (wr_c && reg_sel == REG_N_BODIES && !busy_c) n_bodies_q <= bus.writedata[CFG_W-1:0];
      if (wr_c && reg_sel == REG_ITERS && !busy_c) iters_q <= bus.writedata[CFG_W-1:0];

      if (abort_c) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_c) begin
              if (cfg_ok_c) begin
                state_q    <= S_ACCEL;
                cfg_err_q  <= 1'b0;
                done_q     <= 1'b0;
                iter_cnt_q <= '0;
                i_q        <= '0;
                j_q        <= '0;
              end else begin
                state_q   <= S_IDLE;
                cfg_err_q <= 1'b1;
              end
            end else if (state_q == S_DONE && !done_q) begin
              state_q <= S_IDLE;
            end
          end
          S_ACCEL: begin
            if (j_q == n_last) begin
              j_q <= '0;
              if (i_q == n_last) state_q <= S_DRAIN_A;
              else               i_q     <= i_q + BODY_AW'(1);
            end else begin
              j_q <= j_q + BODY_AW'(1);
            end
          end
          S_DRAIN_A: begin
            if (!pair_busy && !v_busy) begin
              state_q <= S_UPDATE;
              pcnt_q  <= '0;
            end
          end
          S_UPDATE: begin
            if (pcnt_q == n_last) state_q <= S_DRAIN_U;
            else                  pcnt_q  <= pcnt_q + BODY_AW'(1);
          end
          S_DRAIN_U: begin
            if (!p_busy) begin
              iter_cnt_q <= iter_cnt_q + CFG_W'(1);
              if (last_iter_c) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_ACCEL;
                i_q     <= '0;
                j_q     <= '0;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  nbody_delay #(.DEPTH(RAM_LAT), .WIDTH(BODY_AW + 2)) u_pair_dly (
    .clk(clk), .rst(rst), .flush_i(abort_c),
    .vld_i(pvld_c), .data_i({first_c, last_c, pvld_c ? i_q : '0}),
    .vld_o(pair_valid), .data_o(pair_data), .busy_o(pair_busy)
  );

  assign acc_first = pair_data[BODY_AW+1];
  assign acc_last  = pair_data[BODY_AW];
  assign pair_i    = pair_data[BODY_AW-1:0];

  nbody_delay #(.DEPTH(ACCL_LAT + ADD_LAT), .WIDTH(BODY_AW)) u_vel_dly (
    .clk(clk), .rst(rst), .flush_i(abort_c),
    .vld_i(pair_valid & acc_last), .data_i(acc_last ? pair_i : '0),
    .vld_o(v_wr_en), .data_o(v_wr_addr), .busy_o(v_busy)
  );

  nbody_delay #(.DEPTH(RAM_LAT + ADD_LAT), .WIDTH(BODY_AW)) u_pos_dly (
    .clk(clk), .rst(rst), .flush_i(abort_c),
    .vld_i(upd_c), .data_i(upd_c ? pcnt_q : '0),
    .vld_o(p_wr_en), .data_o(p_wr_addr), .busy_o(p_busy)
  );

  assign pi_addr      = i_q;
  assign pj_addr      = j_q;
  assign p_rd_addr    = pcnt_q;
  assign busy         = busy_c;
  assign bus.readdata = readdata_q;
  assign bus.irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_nbody_seq.sv
// Directed bench for nbody_seq: register vectors plus multi-cycle run scenarios.
module tb_nbody_seq;

  localparam int unsigned DW   = 64;
  localparam int unsigned AW   = 16;
  localparam int unsigned BAW  = 9;
  localparam int          VLAT = 141;

  localparam logic [3:0] R_CTRL = 4'd0, R_STAT = 4'd1, R_N = 4'd2, R_IT = 4'd3, R_IC = 4'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nbody_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [BAW-1:0] pi_addr, pj_addr, v_wr_addr, p_rd_addr, p_wr_addr;
  logic pair_valid, acc_first, acc_last, v_wr_en, p_wr_en, busy;

  nbody_seq dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pi_addr(pi_addr), .pj_addr(pj_addr), .pair_valid(pair_valid),
    .acc_first(acc_first), .acc_last(acc_last),
    .v_wr_en(v_wr_en), .v_wr_addr(v_wr_addr), .p_rd_addr(p_rd_addr),
    .p_wr_en(p_wr_en), .p_wr_addr(p_wr_addr), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Passive monitor: strobe counts, write-back addresses, acc_last->v_wr_en distance.
  int n_pv = 0, n_first = 0, n_last = 0, n_vw = 0, n_pw = 0, lat_ok = 0, lat_err = 0, mcyc = 0;
  int lastq[$];
  logic [BAW-1:0] vq[$];
  logic [BAW-1:0] pq[$];
  int t_m;

  always @(negedge clk) begin
    mcyc++;
    if (pair_valid) n_pv++;
    if (acc_first) n_first++;
    if (acc_last) begin n_last++; lastq.push_back(mcyc); end
    if (v_wr_en) begin
      n_vw++;
      vq.push_back(v_wr_addr);
      if (lastq.size() == 0) lat_err++;
      else begin
        t_m = lastq.pop_front();
        if (mcyc - t_m == VLAT) lat_ok++; else lat_err++;
      end
    end
    if (p_wr_en) begin n_pw++; pq.push_back(p_wr_addr); end
    if (!busy) lastq.delete();
  end

  int b_pv, b_first, b_last, b_vw, b_pw, b_lat, b_vq, b_pq;

  task automatic snap();
    b_pv = n_pv; b_first = n_first; b_last = n_last; b_vw = n_vw; b_pw = n_pw;
    b_lat = lat_ok; b_vq = vq.size(); b_pq = pq.size();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [63:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.addr = AW'(a); bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [63:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.addr = AW'(a);
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [63:0] exp);
    logic [63:0] d;
    bus_rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_idle(input int max, input string name);
    int k = 0;
    while (busy && k < max) begin @(negedge clk); k++; end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pi"},   64'(pi_addr),    64'd0);
    check({tag, "_pj"},   64'(pj_addr),    64'd0);
    check({tag, "_pv"},   64'(pair_valid), 64'd0);
    check({tag, "_fst"},  64'(acc_first),  64'd0);
    check({tag, "_lst"},  64'(acc_last),   64'd0);
    check({tag, "_vwe"},  64'(v_wr_en),    64'd0);
    check({tag, "_vwa"},  64'(v_wr_addr),  64'd0);
    check({tag, "_prd"},  64'(p_rd_addr),  64'd0);
    check({tag, "_pwe"},  64'(p_wr_en),    64'd0);
    check({tag, "_pwa"},  64'(p_wr_addr),  64'd0);
    check({tag, "_busy"}, 64'(busy),       64'd0);
    check({tag, "_irq"},  64'(bus.irq),    64'd0);
    check({tag, "_rd"},   bus.readdata,    64'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  a;
    logic [63:0] d;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[22];
  logic [63:0] ones;
  logic [63:0] rdv;

  initial begin
    ones = '1;
    vt[0]  = '{1'b0, R_CTRL, 64'd0, 64'd0};
    vt[1]  = '{1'b0, R_STAT, 64'd0, 64'd0};
    vt[2]  = '{1'b0, R_N,    64'd0, 64'd0};
    vt[3]  = '{1'b0, R_IT,   64'd0, 64'd0};
    vt[4]  = '{1'b0, R_IC,   64'd0, 64'd0};
    vt[5]  = '{1'b0, 4'd5,   64'd0, ones};
    vt[6]  = '{1'b0, 4'd15,  64'd0, ones};
    vt[7]  = '{1'b1, R_N,    64'd5, 64'd0};
    vt[8]  = '{1'b0, R_N,    64'd0, 64'd5};
    vt[9]  = '{1'b1, R_IT,   64'd2, 64'd0};
    vt[10] = '{1'b0, R_IT,   64'd0, 64'd2};
    vt[11] = '{1'b1, R_CTRL, 64'd4, 64'd0};
    vt[12] = '{1'b0, R_CTRL, 64'd0, 64'd4};
    vt[13] = '{1'b0, R_STAT, 64'd0, 64'd0};
    vt[14] = '{1'b1, R_CTRL, 64'd0, 64'd0};
    vt[15] = '{1'b0, R_CTRL, 64'd0, 64'd0};
    vt[16] = '{1'b1, R_IC,   64'd7, 64'd0};
    vt[17] = '{1'b0, R_IC,   64'd0, 64'd0};
    vt[18] = '{1'b1, R_STAT, 64'd6, 64'd0};
    vt[19] = '{1'b0, R_STAT, 64'd0, 64'd0};
    vt[20] = '{1'b1, R_CTRL, 64'd2, 64'd0};
    vt[21] = '{1'b0, R_STAT, 64'd0, 64'd0};

    rst = 1'b1;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = '0; bus.writedata = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;

    for (int k = 0; k < 22; k++) begin
      if (vt[k].wr) bus_wr(vt[k].a, vt[k].d);
      else rd_check($sformatf("vec%0d", k), vt[k].a, vt[k].exp);
    end

    // N=3, one iteration
    bus_wr(R_N, 64'd3); bus_wr(R_IT, 64'd1);
    snap();
    bus_wr(R_CTRL, 64'd1);
    check("A_busy", 64'(busy), 64'd1);
    wait_idle(2000, "A_idle");
    check("A_pairs", 64'(n_pv - b_pv), 64'd6);
    check("A_first", 64'(n_first - b_first), 64'd3);
    check("A_last",  64'(n_last - b_last), 64'd3);
    check("A_vw",    64'(n_vw - b_vw), 64'd3);
    check("A_lat",   64'(lat_ok - b_lat), 64'd3);
    check("A_pw",    64'(n_pw - b_pw), 64'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("A_vaddr%0d", k), 64'(vq[b_vq + k]), 64'(k));
      check($sformatf("A_paddr%0d", k), 64'(pq[b_pq + k]), 64'(k));
    end
    check("A_irq", 64'(bus.irq), 64'd0);
    rd_check("A_status", R_STAT, 64'd1);
    rd_check("A_iters", R_IC, 64'd1);
    bus_wr(R_STAT, 64'd1);
    rd_check("A_clr", R_STAT, 64'd0);

    // N=1 rejected
    bus_wr(R_N, 64'd1);
    snap();
    bus_wr(R_CTRL, 64'd1);
    check("B_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    check("B_busy2", 64'(busy), 64'd0);
    check("B_strobes", 64'((n_pv - b_pv) + (n_vw - b_vw) + (n_pw - b_pw)), 64'd0);
    rd_check("B_status", R_STAT, 64'd4);

    // N=2, ITERS=0 behaves as one iteration; success clears cfg_err
    bus_wr(R_N, 64'd2); bus_wr(R_IT, 64'd0);
    snap();
    bus_wr(R_CTRL, 64'd1);
    wait_idle(2000, "B2_idle");
    check("B2_pairs", 64'(n_pv - b_pv), 64'd2);
    check("B2_first", 64'(n_first - b_first), 64'd2);
    check("B2_last",  64'(n_last - b_last), 64'd2);
    check("B2_vw",    64'(n_vw - b_vw), 64'd2);
    check("B2_pw",    64'(n_pw - b_pw), 64'd2);
    rd_check("B2_status", R_STAT, 64'd1);
    rd_check("B2_iters", R_IC, 64'd1);
    bus_wr(R_STAT, 64'd1);

    // Config writes ignored while busy
    bus_wr(R_N, 64'd3); bus_wr(R_IT, 64'd1);
    snap();
    bus_wr(R_CTRL, 64'd1);
    bus_wr(R_N, 64'd7);
    rd_check("E_n", R_N, 64'd3);
    bus_wr(R_IT, 64'd5);
    rd_check("E_it", R_IT, 64'd1);
    wait_idle(2000, "E_idle");
    check("E_pairs", 64'(n_pv - b_pv), 64'd6);
    check("E_vw",    64'(n_vw - b_vw), 64'd3);
    rd_check("E_iters", R_IC, 64'd1);
    bus_wr(R_STAT, 64'd1);

    // N=4, three iterations with interrupt
    bus_wr(R_N, 64'd4); bus_wr(R_IT, 64'd3);
    snap();
    bus_wr(R_CTRL, 64'd5);
    check("C_irq0", 64'(bus.irq), 64'd0);
    wait_idle(5000, "C_idle");
    check("C_irq1",  64'(bus.irq), 64'd1);
    check("C_pairs", 64'(n_pv - b_pv), 64'd36);
    check("C_vw",    64'(n_vw - b_vw), 64'd12);
    check("C_lat",   64'(lat_ok - b_lat), 64'd12);
    check("C_pw",    64'(n_pw - b_pw), 64'd12);
    rd_check("C_status", R_STAT, 64'd1);
    rd_check("C_iters", R_IC, 64'd3);
    bus_wr(R_STAT, 64'd1);
    check("C_irq_clr", 64'(bus.irq), 64'd0);
    check("C_rd_hold", bus.readdata, 64'd3);
    rd_check("C_status2", R_STAT, 64'd0);

    // Abort in DRAIN_A five cycles before the first velocity strobe
    bus_wr(R_N, 64'd3); bus_wr(R_IT, 64'd1); bus_wr(R_CTRL, 64'd0);
    snap();
    bus_wr(R_CTRL, 64'd1);
    begin
      int k = 0;
      while (!acc_last && k < 50) begin @(negedge clk); k++; end
      check("D_seen_last", 64'(acc_last), 64'd1);
    end
    repeat (135) @(negedge clk);
    check("D_busy_pre", 64'(busy), 64'd1);
    bus_wr(R_CTRL, 64'd2);
    check("D_idle", 64'(busy), 64'd0);
    repeat (200) @(negedge clk);
    check("D_vw", 64'(n_vw - b_vw), 64'd0);
    check("D_pw", 64'(n_pw - b_pw), 64'd0);
    rd_check("D_status", R_STAT, 64'd0);

    // Reset mid-UPDATE
    snap();
    bus_wr(R_CTRL, 64'd1);
    begin
      int k = 0;
      int seen = 0;
      while (seen < 3 && k < 600) begin
        @(negedge clk); k++;
        if (v_wr_en) seen++;
      end
      check("F_vseen", 64'(seen), 64'd3);
    end
    repeat (3) @(negedge clk);
    check("F_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_zero("F");
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("F_busy_after", 64'(busy), 64'd0);
    check("F_pw", 64'(n_pw - b_pw), 64'd0);
    rd_check("F_n", R_N, 64'd0);
    rd_check("F_status", R_STAT, 64'd0);

    check("lat_errors", 64'(lat_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
